// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared encodings for the pipeline hazard controller: forward
//             select codes, result-source codes, Tuse/Tnew widths and the
//             saturating Tnew decrement used when a record advances E->M.
//  Revision : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // Record field widths
    localparam int TNEW_W  = 2;
    localparam int TUSE_W  = 2;
    localparam int SRC_W   = 2;
    localparam int FWD_D_W = 3;
    localparam int FWD_E_W = 3;
    localparam int FWD_M_W = 2;

    // Result source of the instruction that owns a record
    localparam logic [SRC_W-1:0] SRC_ALU = 2'd0;
    localparam logic [SRC_W-1:0] SRC_DM  = 2'd1;
    localparam logic [SRC_W-1:0] SRC_PC8 = 2'd2;

    // Tuse value meaning "this operand is not read"
    localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

    // D-stage (branch compare) operand select
    localparam logic [FWD_D_W-1:0] FWD_D_GRF   = 3'd0;
    localparam logic [FWD_D_W-1:0] FWD_D_PC8_E = 3'd1;
    localparam logic [FWD_D_W-1:0] FWD_D_ALU_M = 3'd2;
    localparam logic [FWD_D_W-1:0] FWD_D_PC8_M = 3'd3;
    localparam logic [FWD_D_W-1:0] FWD_D_WB    = 3'd4;
    localparam logic [FWD_D_W-1:0] FWD_D_PC8_W = 3'd5;

    // E-stage (ALU) operand select
    localparam logic [FWD_E_W-1:0] FWD_E_REG   = 3'd0;
    localparam logic [FWD_E_W-1:0] FWD_E_ALU_M = 3'd1;
    localparam logic [FWD_E_W-1:0] FWD_E_PC8_M = 3'd2;
    localparam logic [FWD_E_W-1:0] FWD_E_WB    = 3'd3;
    localparam logic [FWD_E_W-1:0] FWD_E_PC8_W = 3'd4;

    // M-stage (store data) select
    localparam logic [FWD_M_W-1:0] FWD_M_REG   = 2'd0;
    localparam logic [FWD_M_W-1:0] FWD_M_WB    = 2'd1;
    localparam logic [FWD_M_W-1:0] FWD_M_PC8_W = 2'd2;

    // Tnew counts down by one per stage but never wraps below zero
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        logic [TNEW_W-1:0] r;
        r = (t == '0) ? '0 : (t - {{(TNEW_W-1){1'b0}}, 1'b1});
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stage_rec.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stage_rec
//  Purpose  : One pipeline-stage hazard record register. Async reset and the
//             bubble input both load the all-zero record (dst=0, never a
//             hazard source).
//  Revision : 1.0  initial release
// ============================================================================
module hazard_stage_rec
    import hazard_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load_en,
    input  logic             i_bubble,
    input  logic [WIDTH-1:0] i_rec,
    output logic [WIDTH-1:0] o_rec
);

    logic [WIDTH-1:0] r_rec;

    // Capture the upstream record, or a bubble, whenever the stage advances
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rec <= '0;
        end else if (i_load_en) begin
            r_rec <= i_bubble ? '0 : i_rec;
        end
    end

    assign o_rec = r_rec;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Hazard controller for the 5-stage core. Keeps dest/Tnew/source
//             records for E, M and W, and produces the stall request plus the
//             forward selects for the D compare, E ALU and M store-data muxes.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_AW-1:0]   rs_D,
    input  logic [REG_AW-1:0]   rt_D,
    input  logic [TUSE_W-1:0]   tuse_rs_D,
    input  logic [TUSE_W-1:0]   tuse_rt_D,
    input  logic [REG_AW-1:0]   dst_D,
    input  logic [TNEW_W-1:0]   tnew_D,
    input  logic [SRC_W-1:0]    src_D,
    output logic                stall,
    output logic [FWD_D_W-1:0]  fwd_rs_D,
    output logic [FWD_D_W-1:0]  fwd_rt_D,
    output logic [FWD_E_W-1:0]  fwd_rs_E,
    output logic [FWD_E_W-1:0]  fwd_rt_E,
    output logic [FWD_M_W-1:0]  fwd_rt_M
);

    // Packed record widths: E{rs,rt,dst,tnew,src}, M{rt,dst,tnew,src}, W{dst,src}
    localparam int E_W = 3 * REG_AW + TNEW_W + SRC_W;
    localparam int M_W = 2 * REG_AW + TNEW_W + SRC_W;
    localparam int W_W = REG_AW + SRC_W;

    logic [E_W-1:0]    w_e_next;
    logic [E_W-1:0]    w_e_rec;
    logic [M_W-1:0]    w_m_next;
    logic [M_W-1:0]    w_m_rec;
    logic [W_W-1:0]    w_w_next;
    logic [W_W-1:0]    w_w_rec;

    logic [REG_AW-1:0] w_e_rs;
    logic [REG_AW-1:0] w_e_rt;
    logic [REG_AW-1:0] w_e_dst;
    logic [TNEW_W-1:0] w_e_tnew;
    logic [SRC_W-1:0]  w_e_src;
    logic [REG_AW-1:0] w_m_rt;
    logic [REG_AW-1:0] w_m_dst;
    logic [TNEW_W-1:0] w_m_tnew;
    logic [SRC_W-1:0]  w_m_src;
    logic [REG_AW-1:0] w_w_dst;
    logic [SRC_W-1:0]  w_w_src;

    logic              w_stall;

    assign {w_e_rs, w_e_rt, w_e_dst, w_e_tnew, w_e_src} = w_e_rec;
    assign {w_m_rt, w_m_dst, w_m_tnew, w_m_src}         = w_m_rec;
    assign {w_w_dst, w_w_src}                           = w_w_rec;

    assign w_e_next = {rs_D, rt_D, dst_D, tnew_D, src_D};
    assign w_m_next = {w_e_rt, w_e_dst, sat_dec(w_e_tnew), w_e_src};
    assign w_w_next = {w_m_dst, w_m_src};

    // A stalled D instruction stays put, so E receives a bubble instead
    hazard_stage_rec #(.WIDTH(E_W)) u_rec_e (
        .clk       (clk),
        .reset     (reset),
        .i_load_en (1'b1),
        .i_bubble  (w_stall),
        .i_rec     (w_e_next),
        .o_rec     (w_e_rec)
    );

    hazard_stage_rec #(.WIDTH(M_W)) u_rec_m (
        .clk       (clk),
        .reset     (reset),
        .i_load_en (1'b1),
        .i_bubble  (1'b0),
        .i_rec     (w_m_next),
        .o_rec     (w_m_rec)
    );

    hazard_stage_rec #(.WIDTH(W_W)) u_rec_w (
        .clk       (clk),
        .reset     (reset),
        .i_load_en (1'b1),
        .i_bubble  (1'b0),
        .i_rec     (w_w_next),
        .o_rec     (w_w_rec)
    );

    // An operand stalls when a producer in E or M will not have its result
    // ready by the time this instruction needs it
    function automatic logic operand_stall(
        input logic [REG_AW-1:0] r,
        input logic [TUSE_W-1:0] tuse,
        input logic [REG_AW-1:0] e_dst,
        input logic [TNEW_W-1:0] e_tnew,
        input logic [REG_AW-1:0] m_dst,
        input logic [TNEW_W-1:0] m_tnew
    );
        logic hit;
        hit = 1'b0;
        if ((r != '0) && (tuse != TUSE_NONE)) begin
            if ((r == e_dst) && (e_tnew > tuse)) hit = 1'b1;
            if ((r == m_dst) && (m_tnew > tuse)) hit = 1'b1;
        end
        return hit;
    endfunction

    // D compare select: newest producer wins; a not-yet-ready E/M producer
    // blocks older stages and yields GRF, since the stall covers that case
    function automatic logic [FWD_D_W-1:0] fwd_d_sel(
        input logic [REG_AW-1:0] r,
        input logic [REG_AW-1:0] e_dst,
        input logic [TNEW_W-1:0] e_tnew,
        input logic [REG_AW-1:0] m_dst,
        input logic [TNEW_W-1:0] m_tnew,
        input logic [SRC_W-1:0]  m_src,
        input logic [REG_AW-1:0] w_dst,
        input logic [SRC_W-1:0]  w_src
    );
        logic [FWD_D_W-1:0] sel;
        sel = FWD_D_GRF;
        if (r != '0) begin
            if (r == e_dst) begin
                if (e_tnew == '0) sel = FWD_D_PC8_E;
            end else if (r == m_dst) begin
                if (m_tnew == '0) sel = (m_src == SRC_PC8) ? FWD_D_PC8_M : FWD_D_ALU_M;
            end else if (r == w_dst) begin
                sel = (w_src == SRC_PC8) ? FWD_D_PC8_W : FWD_D_WB;
            end
        end
        return sel;
    endfunction

    // E ALU select: M beats W; a not-ready M producer yields the register value
    function automatic logic [FWD_E_W-1:0] fwd_e_sel(
        input logic [REG_AW-1:0] r,
        input logic [REG_AW-1:0] m_dst,
        input logic [TNEW_W-1:0] m_tnew,
        input logic [SRC_W-1:0]  m_src,
        input logic [REG_AW-1:0] w_dst,
        input logic [SRC_W-1:0]  w_src
    );
        logic [FWD_E_W-1:0] sel;
        sel = FWD_E_REG;
        if (r != '0) begin
            if (r == m_dst) begin
                if (m_tnew == '0) sel = (m_src == SRC_PC8) ? FWD_E_PC8_M : FWD_E_ALU_M;
            end else if (r == w_dst) begin
                sel = (w_src == SRC_PC8) ? FWD_E_PC8_W : FWD_E_WB;
            end
        end
        return sel;
    endfunction

    // Stall request from either D operand
    always_comb begin
        w_stall = operand_stall(rs_D, tuse_rs_D, w_e_dst, w_e_tnew, w_m_dst, w_m_tnew)
                | operand_stall(rt_D, tuse_rt_D, w_e_dst, w_e_tnew, w_m_dst, w_m_tnew);
    end

    assign stall = w_stall;

    // Forward selects for the D compare operands
    always_comb begin
        fwd_rs_D = fwd_d_sel(rs_D, w_e_dst, w_e_tnew, w_m_dst, w_m_tnew, w_m_src, w_w_dst, w_w_src);
        fwd_rt_D = fwd_d_sel(rt_D, w_e_dst, w_e_tnew, w_m_dst, w_m_tnew, w_m_src, w_w_dst, w_w_src);
    end

    // Forward selects for the E ALU operands, keyed by the E record's sources
    always_comb begin
        fwd_rs_E = fwd_e_sel(w_e_rs, w_m_dst, w_m_tnew, w_m_src, w_w_dst, w_w_src);
        fwd_rt_E = fwd_e_sel(w_e_rt, w_m_dst, w_m_tnew, w_m_src, w_w_dst, w_w_src);
    end

    // Store-data select for the instruction in M; only W can be newer
    always_comb begin
        fwd_rt_M = FWD_M_REG;
        if ((w_m_rt != '0) && (w_m_rt == w_w_dst)) begin
            fwd_rt_M = (w_w_src == SRC_PC8) ? FWD_M_PC8_W : FWD_M_WB;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit
//  Purpose  : Self-checking bench for hazard_unit. Instruction sequences are
//             listed as per-cycle D inputs with hand-derived expected outputs;
//             reset behaviour is exercised with short hand-written sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_unit;
    import hazard_pkg::*;

    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] rs_D, rt_D, dst_D;
    logic [1:0]        tuse_rs_D, tuse_rt_D, tnew_D, src_D;
    logic              stall;
    logic [2:0]        fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic [1:0]        fwd_rt_M;

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(REG_AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_D      (rs_D),
        .rt_D      (rt_D),
        .tuse_rs_D (tuse_rs_D),
        .tuse_rt_D (tuse_rt_D),
        .dst_D     (dst_D),
        .tnew_D    (tnew_D),
        .src_D     (src_D),
        .stall     (stall),
        .fwd_rs_D  (fwd_rs_D),
        .fwd_rt_D  (fwd_rt_D),
        .fwd_rs_E  (fwd_rs_E),
        .fwd_rt_E  (fwd_rt_E),
        .fwd_rt_M  (fwd_rt_M)
    );

    typedef struct packed {
        logic       st;
        logic [2:0] fd_rs;
        logic [2:0] fd_rt;
        logic [2:0] fe_rs;
        logic [2:0] fe_rt;
        logic [1:0] fm_rt;
    } out_t;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tu_rs;
        logic [1:0] tu_rt;
        logic [4:0] dst;
        logic [1:0] tn;
        logic [1:0] src;
    } din_t;

    typedef struct packed {
        din_t d;
        out_t e;
    } vec_t;

    vec_t  vecs[$];
    out_t  sb[$];
    string sb_tag[$];
    int    errors = 0;
    int    checks = 0;

    function automatic din_t di(int rs, int rt, int tu_rs, int tu_rt, int dst, int tn, int src);
        din_t d;
        d.rs = rs[4:0]; d.rt = rt[4:0]; d.tu_rs = tu_rs[1:0]; d.tu_rt = tu_rt[1:0];
        d.dst = dst[4:0]; d.tn = tn[1:0]; d.src = src[1:0];
        return d;
    endfunction

    function automatic out_t ex(int st, int a, int b, int c, int e, int m);
        out_t o;
        o.st = st[0]; o.fd_rs = a[2:0]; o.fd_rt = b[2:0];
        o.fe_rs = c[2:0]; o.fe_rt = e[2:0]; o.fm_rt = m[1:0];
        return o;
    endfunction

    task automatic add(input din_t d, input out_t e);
        vec_t v;
        v.d = d;
        v.e = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input din_t d);
        rs_D = d.rs; rt_D = d.rt; tuse_rs_D = d.tu_rs; tuse_rt_D = d.tu_rt;
        dst_D = d.dst; tnew_D = d.tn; src_D = d.src;
    endtask

    task automatic drive_random();
        din_t d;
        d = din_t'($urandom());
        drive(d);
    endtask

    task automatic push_exp(input string tag, input out_t e);
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic check_pop();
        out_t  e;
        out_t  a;
        string tag;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e   = sb.pop_front();
            tag = sb_tag.pop_front();
            a   = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M};
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got stall=%0d fdrs=%0d fdrt=%0d fers=%0d fert=%0d fmrt=%0d, expected stall=%0d fdrs=%0d fdrt=%0d fers=%0d fert=%0d fmrt=%0d",
                         tag, a.st, a.fd_rs, a.fd_rt, a.fe_rs, a.fe_rt, a.fm_rt,
                         e.st, e.fd_rs, e.fd_rt, e.fe_rs, e.fe_rt, e.fm_rt);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // lw $8 then beq $8: two stall cycles, then WB forward
        add(di( 2,  0, 1, 3,  8, 2, 1), ex(0, 0, 0, 0, 0, 0));
        add(di( 8,  3, 0, 0,  0, 0, 0), ex(1, 0, 0, 0, 0, 0));
        add(di( 8,  3, 0, 0,  0, 0, 0), ex(1, 0, 0, 0, 0, 0));
        add(di( 8,  3, 0, 0,  0, 0, 0), ex(0, 4, 0, 0, 0, 0));
        // add $9, sub uses $9 at E, or uses $9 one later
        add(di( 1,  2, 1, 1,  9, 1, 0), ex(0, 0, 0, 0, 0, 0));
        add(di( 9,  4, 1, 1, 10, 1, 0), ex(0, 0, 0, 0, 0, 0));
        add(di( 9, 10, 1, 1, 11, 1, 0), ex(0, 2, 0, 1, 0, 0));
        add(di( 0,  0, 3, 3,  0, 0, 0), ex(0, 0, 0, 3, 1, 0));
        // jal then jr $31 in successive positions
        add(di( 0,  0, 3, 3, 31, 0, 2), ex(0, 0, 0, 0, 0, 1));
        add(di(31,  0, 0, 3,  0, 0, 0), ex(0, 1, 0, 0, 0, 0));
        add(di(31,  0, 0, 3,  0, 0, 0), ex(0, 3, 0, 2, 0, 0));
        add(di(31,  0, 0, 3,  0, 0, 0), ex(0, 5, 0, 4, 0, 0));
        // add $5, add $5, sw $5: newer M producer beats W
        add(di( 1,  2, 1, 1,  5, 1, 0), ex(0, 0, 0, 0, 0, 0));
        add(di( 5,  3, 1, 1,  5, 1, 0), ex(0, 0, 0, 0, 0, 0));
        add(di( 6,  5, 1, 2,  0, 0, 0), ex(0, 0, 0, 1, 0, 0));
        add(di( 0,  0, 3, 3,  0, 0, 0), ex(0, 0, 0, 0, 1, 0));
        // addu $0 then beq $0: reg 0 never matches
        add(di( 1,  2, 1, 1,  0, 1, 0), ex(0, 0, 0, 0, 0, 1));
        add(di( 0,  0, 0, 0,  0, 0, 0), ex(0, 0, 0, 0, 0, 0));
        // lw $7 then sw $7: store data from W load
        add(di( 1,  0, 1, 3,  7, 2, 1), ex(0, 0, 0, 0, 0, 0));
        add(di( 2,  7, 1, 2,  0, 0, 0), ex(0, 0, 0, 0, 0, 0));
        add(di( 0,  0, 3, 3,  0, 0, 0), ex(0, 0, 0, 0, 0, 0));
        add(di( 0,  0, 3, 3,  0, 0, 0), ex(0, 0, 0, 0, 0, 1));
        // lw $12: unused operand ignored, then one stall via M
        add(di( 1,  0, 1, 3, 12, 2, 1), ex(0, 0, 0, 0, 0, 0));
        add(di(12,  0, 3, 3,  0, 0, 0), ex(0, 0, 0, 0, 0, 0));
        add(di(12,  0, 0, 3, 13, 1, 0), ex(1, 0, 0, 0, 0, 0));
        add(di(12,  0, 0, 3, 13, 1, 0), ex(0, 4, 0, 0, 0, 0));
        // rt forwarding, PC8 paths, stall together with forwarding
        add(di( 0,  0, 3, 3,  0, 0, 0), ex(0, 0, 0, 0, 0, 0));
        add(di( 0,  0, 3, 3, 31, 0, 2), ex(0, 0, 0, 0, 0, 0));
        add(di(13, 31, 0, 0,  0, 0, 0), ex(0, 4, 1, 0, 0, 0));
        add(di( 1,  0, 1, 3, 14, 2, 1), ex(0, 0, 0, 0, 2, 0));
        add(di(31, 14, 0, 0,  0, 0, 0), ex(1, 5, 0, 0, 0, 2));

        // Reset held with arbitrary D inputs
        reset = 1'b1;
        drive_random();
        push_exp("reset_t0", ex(0, 0, 0, 0, 0, 0));
        #2;
        check_pop();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive_random();
            push_exp($sformatf("reset_hold%0d", k), ex(0, 0, 0, 0, 0, 0));
            @(negedge clk);
            check_pop();
        end

        // Release: records remain bubble until the first edge
        @(posedge clk); #1;
        reset = 1'b0;
        drive(di(8, 3, 0, 0, 0, 0, 0));
        push_exp("release", ex(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check_pop();
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].d);
            push_exp($sformatf("row%0d", i), vecs[i].e);
            @(negedge clk);
            check_pop();
            @(posedge clk); #1;
        end

        // Reset asserted mid-stall clears the records immediately
        drive(di(14, 0, 0, 3, 0, 0, 0));
        push_exp("pre_reset_stall", ex(1, 0, 0, 0, 0, 0));
        #2;
        check_pop();
        reset = 1'b1;
        push_exp("async_reset", ex(0, 0, 0, 0, 0, 0));
        #1;
        check_pop();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            drive_random();
            push_exp($sformatf("mid_reset%0d", k), ex(0, 0, 0, 0, 0, 0));
            @(negedge clk);
            check_pop();
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive(di(14, 0, 0, 3, 0, 0, 0));
        push_exp("post_reset", ex(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check_pop();
        @(posedge clk); #1;
        drive(di(0, 0, 3, 3, 0, 0, 0));
        push_exp("post_reset_nop", ex(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check_pop();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
